// File: rtl/dbus_if.sv
// Load/store data-bus bundle between the CPU core and the data-bus target,
// including the debug TX stream and interrupt line.
interface dbus_if;
    logic [15:0] raddr;
    logic        re;
    logic [15:0] rdata;
    logic [15:0] waddr;
    logic [15:0] wdata;
    logic        we;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        irq;

    modport master (
        output raddr, re, waddr, wdata, we, tx_ready,
        input  rdata, tx_data, tx_valid, irq
    );

    modport slave (
        input  raddr, re, waddr, wdata, we, tx_ready,
        output rdata, tx_data, tx_valid, irq
    );
endinterface

// File: rtl/dbus_target.sv
// Data-bus responder: word RAM plus an 8-word MMIO window holding a TX FIFO,
// status/sticky flags, a 32-bit cycle counter with hi-latch and a scratch word.
module dbus_target #(
    parameter int unsigned RAM_WORDS  = 256,
    parameter logic [15:0] MMIO_BASE  = 16'hFF00,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    dbus_if.slave  bus
);

    localparam int unsigned AW = $clog2(RAM_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [2:0] OFF_TXDATA  = 3'd0;
    localparam logic [2:0] OFF_STATUS  = 3'd1;
    localparam logic [2:0] OFF_CYC_LO  = 3'd2;
    localparam logic [2:0] OFF_CYC_HI  = 3'd3;
    localparam logic [2:0] OFF_SCRATCH = 3'd4;

    logic [15:0]   ram_q  [RAM_WORDS];
    logic [15:0]   fifo_q [FIFO_DEPTH];
    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   cyc_q;
    logic [15:0]   cyc_hi_q, cyc_hi_d;
    logic [15:0]   scratch_q, scratch_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          ovf_q, ovf_d;
    logic          berr_q, berr_d;
    logic          irq_q;

    logic [15:0]   roff_c, woff_c;
    logic          r_ram_c, r_mmio_c, w_ram_c, w_mmio_c;
    logic [CW-1:0] count_c;
    logic          empty_c, full_c, pop_c, push_req_c, push_c, w1c_c, berr_set_c;
    logic [3:0]    cnt_sat_c;
    logic [15:0]   status_c;

    // Address decode for both ports; RAM takes priority over the MMIO window.
    always_comb begin
        roff_c   = bus.raddr - MMIO_BASE;
        woff_c   = bus.waddr - MMIO_BASE;
        r_ram_c  = 32'(bus.raddr) < RAM_WORDS;
        w_ram_c  = 32'(bus.waddr) < RAM_WORDS;
        r_mmio_c = !r_ram_c && (roff_c < 16'd8);
        w_mmio_c = !w_ram_c && (woff_c < 16'd8);
    end

    // FIFO occupancy, handshake qualification and the STATUS word (pre-edge view).
    always_comb begin
        count_c    = wr_ptr_q - rd_ptr_q;
        empty_c    = (count_c == '0);
        full_c     = (count_c == CW'(FIFO_DEPTH));
        pop_c      = !empty_c && bus.tx_ready;
        push_req_c = bus.we && w_mmio_c && (woff_c[2:0] == OFF_TXDATA);
        push_c     = push_req_c && (!full_c || pop_c);
        w1c_c      = bus.we && w_mmio_c && (woff_c[2:0] == OFF_STATUS);
        berr_set_c = (bus.we && !w_ram_c && !w_mmio_c) ||
                     (bus.re && !r_ram_c && !r_mmio_c);
        cnt_sat_c  = (32'(count_c) > 32'd15) ? 4'hF : 4'(count_c);
        status_c   = {8'h00, cnt_sat_c, berr_q, ovf_q, full_c, empty_c};
    end

    // Next-state for read data, pointers, sticky bits, scratch and hi-latch.
    always_comb begin
        rdata_d   = rdata_q;
        cyc_hi_d  = cyc_hi_q;
        scratch_d = scratch_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ovf_d     = ovf_q;
        berr_d    = berr_q;

        if (bus.re) begin
            rdata_d = 16'h0000;
            if (r_ram_c) begin
                rdata_d = ram_q[bus.raddr[AW-1:0]];
            end else if (r_mmio_c) begin
                case (roff_c[2:0])
                    OFF_STATUS:  rdata_d = status_c;
                    OFF_CYC_LO: begin
                        rdata_d  = cyc_q[15:0];
                        cyc_hi_d = cyc_q[31:16];
                    end
                    OFF_CYC_HI:  rdata_d = cyc_hi_q;
                    OFF_SCRATCH: rdata_d = scratch_q;
                    default:     rdata_d = 16'h0000;
                endcase
            end
        end

        if (bus.we && w_mmio_c && (woff_c[2:0] == OFF_SCRATCH)) begin
            scratch_d = bus.wdata;
        end

        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + CW'(1);
        end
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + CW'(1);
        end

        // Clear first so a coincident set event wins.
        if (w1c_c && bus.wdata[2]) begin
            ovf_d = 1'b0;
        end
        if (w1c_c && bus.wdata[3]) begin
            berr_d = 1'b0;
        end
        if (push_req_c && !push_c) begin
            ovf_d = 1'b1;
        end
        if (berr_set_c) begin
            berr_d = 1'b1;
        end
    end

    // Resettable state: control registers, counter, FIFO storage and irq.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q   <= 16'h0000;
            cyc_q     <= 32'h0000_0000;
            cyc_hi_q  <= 16'h0000;
            scratch_q <= 16'h0000;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovf_q     <= 1'b0;
            berr_q    <= 1'b0;
            irq_q     <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_q[i] <= 16'h0000;
            end
        end else begin
            rdata_q   <= rdata_d;
            cyc_q     <= cyc_q + 32'd1;
            cyc_hi_q  <= cyc_hi_d;
            scratch_q <= scratch_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ovf_q     <= ovf_d;
            berr_q    <= berr_d;
            irq_q     <= ovf_q | berr_q;
            if (push_c) begin
                fifo_q[wr_ptr_q[PW-1:0]] <= bus.wdata;
            end
        end
    end

    // RAM array; contents survive reset.
    always_ff @(posedge clk) begin
        if (bus.we && w_ram_c) begin
            ram_q[bus.waddr[AW-1:0]] <= bus.wdata;
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.tx_valid = !empty_c;
    assign bus.tx_data  = fifo_q[rd_ptr_q[PW-1:0]];
    assign bus.irq      = irq_q;

endmodule

// File: tb/tb_dbus_target.sv
// Self-checking bench for dbus_target: directed vector table, counter snapshot,
// async reset mid-stream and a randomized run against a queue-based model.
module tb_dbus_target;

    localparam logic [15:0] MB = 16'hFF00;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dbus_if bus ();

    dbus_target #(.RAM_WORDS(256), .MMIO_BASE(MB), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    int unsigned edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic        re;
        logic [15:0] raddr;
        logic        we;
        logic [15:0] waddr;
        logic [15:0] wdata;
        logic        rdy;
        logic [15:0] e_rdata;
        logic        e_valid;
        logic [15:0] e_data;
        logic        e_irq;
    } vec_t;

    vec_t vq[$];

    // Behavioural model state for the randomized phase
    logic [15:0] m_ram [16];
    logic [15:0] m_q[$];
    logic        m_ovf, m_berr;
    logic [15:0] m_scr, m_rdata;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic re, input logic [15:0] ra, input logic we,
                         input logic [15:0] wa, input logic [15:0] wd, input logic rdy);
        bus.re       = re;
        bus.raddr    = ra;
        bus.we       = we;
        bus.waddr    = wa;
        bus.wdata    = wd;
        bus.tx_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic re, input logic [15:0] ra, input logic we,
                       input logic [15:0] wa, input logic [15:0] wd, input logic rdy,
                       input logic [15:0] er, input logic ev, input logic [15:0] ed,
                       input logic ei);
        vec_t v;
        v.re = re; v.raddr = ra; v.we = we; v.waddr = wa; v.wdata = wd; v.rdy = rdy;
        v.e_rdata = er; v.e_valid = ev; v.e_data = ed; v.e_irq = ei;
        vq.push_back(v);
    endtask

    function automatic logic [15:0] m_status();
        int c;
        logic [3:0] cs;
        c  = m_q.size();
        cs = (c > 15) ? 4'hF : 4'(c);
        return {8'h00, cs, m_berr, m_ovf, (c == 4), (c == 0)};
    endfunction

    function automatic logic [15:0] pick_addr(input bit is_write);
        logic [15:0] a;
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: a = 16'($urandom_range(0, 15));
            5:       a = MB;
            6:       a = MB + 16'd1;
            7:       a = MB + 16'd4;
            8:       a = is_write ? MB + 16'($urandom_range(2, 7)) : MB + 16'($urandom_range(5, 7));
            default: a = is_write ? (($urandom_range(0, 1) == 0) ? 16'h8000 : 16'h0100) : MB;
        endcase
        return a;
    endfunction

    int unsigned rel_edge;
    logic [31:0] exp_cnt;
    logic        r_re, r_we, r_rdy, pop, full_before, exp_irq;
    logic [15:0] ra, wa, wd, exp_rd;

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        tick();
        check("reset_rdata", bus.rdata, 16'h0000);
        check("reset_tx_valid", 16'(bus.tx_valid), 16'h0000);
        check("reset_irq", 16'(bus.irq), 16'h0000);
        tick();
        rst_n = 1'b1;

        // re, raddr, we, waddr, wdata, rdy | rdata, valid, data, irq (after the edge)
        add(0, 16'h0000, 1, 16'h0005, 16'hBEEF, 0, 16'h0000, 0, 16'h0000, 0);
        add(1, 16'h0005, 0, 16'h0000, 16'h0000, 0, 16'hBEEF, 0, 16'h0000, 0);
        add(1, 16'h0005, 1, 16'h0005, 16'h1234, 0, 16'hBEEF, 0, 16'h0000, 0);
        add(1, 16'h0005, 0, 16'h0000, 16'h0000, 0, 16'h1234, 0, 16'h0000, 0);
        add(0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h1234, 0, 16'h0000, 0);
        for (int k = 1; k <= 4; k++)
            add(0, 16'h0000, 1, MB, 16'(k), 0, 16'h1234, 1, 16'h0001, 0);
        add(1, MB + 16'd1, 0, 16'h0000, 16'h0000, 0, 16'h0042, 1, 16'h0001, 0);
        add(0, 16'h0000, 1, MB, 16'h0005, 0, 16'h0042, 1, 16'h0001, 0);
        add(1, MB + 16'd1, 0, 16'h0000, 16'h0000, 0, 16'h0046, 1, 16'h0001, 1);
        add(1, MB, 0, 16'h0000, 16'h0000, 1, 16'h0000, 1, 16'h0002, 1);
        add(0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0000, 1, 16'h0003, 1);
        add(0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0000, 1, 16'h0004, 1);
        add(0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0000, 0, 16'h0000, 1);
        add(0, 16'h0000, 1, MB + 16'd1, 16'h0004, 0, 16'h0000, 0, 16'h0000, 1);
        add(1, MB + 16'd1, 0, 16'h0000, 16'h0000, 0, 16'h0001, 0, 16'h0000, 0);
        add(1, MB + 16'd4, 1, MB + 16'd4, 16'hA5A5, 0, 16'h0000, 0, 16'h0000, 0);
        add(1, MB + 16'd4, 0, 16'h0000, 16'h0000, 0, 16'hA5A5, 0, 16'h0000, 0);
        add(1, MB + 16'd5, 1, MB + 16'd6, 16'h1234, 0, 16'h0000, 0, 16'h0000, 0);
        add(1, MB + 16'd6, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);
        add(1, MB + 16'd1, 0, 16'h0000, 16'h0000, 0, 16'h0001, 0, 16'h0000, 0);
        for (int k = 1; k <= 4; k++)
            add(0, 16'h0000, 1, MB, 16'(k), 0, 16'h0001, 1, 16'h0001, 0);
        add(0, 16'h0000, 1, MB, 16'h0009, 1, 16'h0001, 1, 16'h0002, 0);
        add(1, MB + 16'd1, 0, 16'h0000, 16'h0000, 0, 16'h0042, 1, 16'h0002, 0);
        add(0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0042, 1, 16'h0003, 0);
        add(0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0042, 1, 16'h0004, 0);
        add(0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0042, 1, 16'h0009, 0);
        add(0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0042, 0, 16'h0000, 0);
        add(1, MB + 16'd1, 0, 16'h0000, 16'h0000, 0, 16'h0001, 0, 16'h0000, 0);
        add(0, 16'h0000, 1, 16'h8000, 16'h1234, 0, 16'h0001, 0, 16'h0000, 0);
        add(1, MB + 16'd1, 0, 16'h0000, 16'h0000, 0, 16'h0009, 0, 16'h0000, 1);
        add(0, 16'h0000, 1, MB + 16'd1, 16'h0008, 0, 16'h0009, 0, 16'h0000, 1);
        add(1, 16'h8000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);

        foreach (vq[i]) begin
            drive(vq[i].re, vq[i].raddr, vq[i].we, vq[i].waddr, vq[i].wdata, vq[i].rdy);
            tick();
            check($sformatf("vec%0d_rdata", i), bus.rdata, vq[i].e_rdata);
            check($sformatf("vec%0d_tx_valid", i), 16'(bus.tx_valid), 16'(vq[i].e_valid));
            if (vq[i].e_valid)
                check($sformatf("vec%0d_tx_data", i), bus.tx_data, vq[i].e_data);
            check($sformatf("vec%0d_irq", i), 16'(bus.irq), 16'(vq[i].e_irq));
        end

        // Cycle counter snapshot after a fresh reset
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rel_edge = edge_cnt;
        repeat (70000) tick();
        drive(1, MB + 16'd2, 0, 0, 0, 0);
        exp_cnt = 32'(edge_cnt - rel_edge);
        tick();
        check("cyc_lo", bus.rdata, exp_cnt[15:0]);
        drive(1, MB + 16'd3, 0, 0, 0, 0);
        tick();
        check("cyc_hi", bus.rdata, exp_cnt[31:16]);
        check("cyc_hi_is_one", bus.rdata, 16'h0001);
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        drive(1, MB + 16'd3, 0, 0, 0, 0);
        tick();
        check("cyc_hi_reread", bus.rdata, exp_cnt[31:16]);

        // Async reset while the FIFO holds data
        drive(0, 0, 1, MB, 16'h0011, 0); tick();
        drive(0, 0, 1, MB, 16'h0022, 0); tick();
        drive(0, 0, 1, MB + 16'd4, 16'hA5A5, 0); tick();
        drive(1, MB + 16'd4, 0, 0, 0, 0); tick();
        check("pre_rst_scratch", bus.rdata, 16'hA5A5);
        check("pre_rst_tx_valid", 16'(bus.tx_valid), 16'h0001);
        drive(0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #2;
        check("async_rst_tx_valid", 16'(bus.tx_valid), 16'h0000);
        check("async_rst_rdata", bus.rdata, 16'h0000);
        check("async_rst_irq", 16'(bus.irq), 16'h0000);
        #2 rst_n = 1'b1;
        drive(1, MB + 16'd4, 0, 0, 0, 0); tick();
        check("post_rst_scratch", bus.rdata, 16'h0000);
        drive(1, MB + 16'd1, 0, 0, 0, 0); tick();
        check("post_rst_status", bus.rdata, 16'h0001);

        // Randomized phase against the behavioural model
        m_q.delete();
        m_ovf = 1'b0; m_berr = 1'b0; m_scr = 16'h0000; m_rdata = 16'h0001;
        for (int a = 0; a < 16; a++) begin
            m_ram[a] = 16'($urandom);
            drive(0, 0, 1, 16'(a), m_ram[a], 0);
            tick();
        end
        for (int n = 0; n < 3000; n++) begin
            r_re  = 1'($urandom_range(0, 1));
            r_we  = 1'($urandom_range(0, 1));
            r_rdy = 1'($urandom_range(0, 1));
            ra = pick_addr(1'b0);
            wa = pick_addr(1'b1);
            wd = 16'($urandom);

            exp_rd = m_rdata;
            if (r_re) begin
                if (ra < 16'd16)            exp_rd = m_ram[ra[3:0]];
                else if (ra == MB + 16'd1)  exp_rd = m_status();
                else if (ra == MB + 16'd4)  exp_rd = m_scr;
                else                        exp_rd = 16'h0000;
            end
            exp_irq = m_ovf | m_berr;

            full_before = (m_q.size() == 4);
            pop = (m_q.size() > 0) && r_rdy;
            if (r_we && wa == MB + 16'd1) begin
                if (wd[2]) m_ovf = 1'b0;
                if (wd[3]) m_berr = 1'b0;
            end
            if (pop) void'(m_q.pop_front());
            if (r_we && wa == MB) begin
                if (!full_before || pop) m_q.push_back(wd);
                else                     m_ovf = 1'b1;
            end
            if (r_we && (wa == 16'h8000 || wa == 16'h0100)) m_berr = 1'b1;
            if (r_we && wa < 16'd16) m_ram[wa[3:0]] = wd;
            if (r_we && wa == MB + 16'd4) m_scr = wd;
            m_rdata = exp_rd;

            drive(r_re, ra, r_we, wa, wd, r_rdy);
            tick();
            check($sformatf("rnd%0d_rdata", n), bus.rdata, exp_rd);
            check($sformatf("rnd%0d_irq", n), 16'(bus.irq), 16'(exp_irq));
            check($sformatf("rnd%0d_tx_valid", n), 16'(bus.tx_valid), 16'(m_q.size() > 0));
            if (m_q.size() > 0)
                check($sformatf("rnd%0d_tx_data", n), bus.tx_data, m_q[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
